fifo_decimation_sc: RTL and testbench

Single-clock, parametrised Avalon-MM FIFO that replaces the fixed 32x16 dual-clock decimation FIFO wherever producer and consumer share one clock. It adds a run-time decimation factor on the write side, keeping one of every N accepted beats. It also adds a configurable almost-full headroom, a fill-level output and optional stall statistics. It sits between a sample producer (write slave) and a DMA/CPU reader (read slave).

---
 rtl/fifo_decimation_pkg.sv | 23 ++
 rtl/fifo_decimation_sc_mem.sv | 33 +++
 rtl/fifo_decimation_sc.sv | 113 +++++++++++
 tb/tb_fifo_decimation_sc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_decimation_pkg.sv
// fifo_decimation_pkg
// Shared sizing helpers and statistics arithmetic for fifo_decimation_sc.
//   addr_w(depth) : pointer width for a DEPTH-entry buffer
//   cnt_w(depth)  : fill-counter width able to hold 0..DEPTH
//   STALL_CNT_W   : width of the write-stall statistics counter
//   sat_inc(v)    : increment that sticks at all-ones
package fifo_decimation_pkg;

    localparam int STALL_CNT_W = 16;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_decimation_sc_mem.sv
// fifo_decimation_sc_mem
// DEPTH x DATA_WIDTH storage array: synchronous write, asynchronous read.
//   clock : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : word at raddr (combinational)
module fifo_decimation_sc_mem
    import fifo_decimation_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                       clock,
    input  logic                       we,
    input  logic [addr_w(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [addr_w(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_decimation_sc.sv
// fifo_decimation_sc
// Single-clock show-ahead FIFO with write-side decimation (keep 1 of every
// N accepted beats), almost-full headroom, fill level and stall statistics.
// Optional feature macro: FIFO_DECIMATION_SC_STATUS_EN -- when defined,
// usedw and stall_count are live; otherwise both ports are tied to 0.
//   clock / reset                     : clock, synchronous active-high reset
//   decim_factor                      : keep 1 of N accepted writes (0,1 = all)
//   avalonmm_write_slave_*            : write port, waitrequest = almost full
//   avalonmm_read_slave_*             : read port, waitrequest = empty
//   usedw                             : fill level 0..DEPTH
//   stall_count                       : saturating count of write-stall cycles
module fifo_decimation_sc
    import fifo_decimation_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int HEADROOM   = 3,
    parameter int DECIM_W    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DECIM_W-1:0]       decim_factor,
    input  logic                     avalonmm_write_slave_write,
    input  logic [DATA_WIDTH-1:0]    avalonmm_write_slave_writedata,
    output logic                     avalonmm_write_slave_waitrequest,
    input  logic                     avalonmm_read_slave_read,
    output logic [DATA_WIDTH-1:0]    avalonmm_read_slave_readdata,
    output logic                     avalonmm_read_slave_waitrequest,
    output logic [$clog2(DEPTH):0]   usedw,
    output logic [STALL_CNT_W-1:0]   stall_count
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(DEPTH - HEADROOM);

    logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      level;
    logic [DECIM_W-1:0]    phase;
    logic [DECIM_W-1:0]    phase_last;
    logic [DATA_WIDTH-1:0] last_pop;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wr_wait, rd_wait, wacc, racc, store;

    // Flags depend only on the registered fill level, never on the requests.
    assign wr_wait = (level >= FULL_TH);
    assign rd_wait = (level == '0);
    assign wacc    = avalonmm_write_slave_write & ~wr_wait;
    assign racc    = avalonmm_read_slave_read & ~rd_wait;
    assign store   = wacc && (phase == '0);

    // Last phase index of the decimation cycle; factor 0 behaves like 1.
    assign phase_last = (decim_factor == '0) ? '0 : decim_factor - 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            phase    <= '0;
            last_pop <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (racc) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_pop <= mem_rdata;
            end
            // ">=" so a factor lowered below the current phase wraps at once.
            if (wacc) phase <= (phase >= phase_last) ? '0 : phase + 1'b1;
            case ({store, racc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    fifo_decimation_sc_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (store),
        .waddr (wr_ptr),
        .wdata (avalonmm_write_slave_writedata),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // When empty, present the last word handed out rather than a stale slot.
    assign avalonmm_read_slave_readdata     = rd_wait ? last_pop : mem_rdata;
    assign avalonmm_read_slave_waitrequest  = rd_wait;
    assign avalonmm_write_slave_waitrequest = wr_wait;

`ifdef FIFO_DECIMATION_SC_STATUS_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (avalonmm_write_slave_write && wr_wait) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign usedw       = level;
    assign stall_count = stall_q;
`else
    assign usedw       = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_decimation_sc.sv
// tb_fifo_decimation_sc
// Directed scoreboard bench for fifo_decimation_sc: stimulus pushes the words
// it expects to be stored; a monitor pops and compares on every read accept.
module tb_fifo_decimation_sc;

`ifdef FIFO_DECIMATION_SC_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  decim_factor;
    logic        write;
    logic [31:0] writedata;
    logic        wr_wait;
    logic        read;
    logic [31:0] readdata;
    logic        rd_wait;
    logic [4:0]  usedw;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    always #5 clock = ~clock;

    fifo_decimation_sc dut (
        .clock                            (clock),
        .reset                            (reset),
        .decim_factor                     (decim_factor),
        .avalonmm_write_slave_write       (write),
        .avalonmm_write_slave_writedata   (writedata),
        .avalonmm_write_slave_waitrequest (wr_wait),
        .avalonmm_read_slave_read         (read),
        .avalonmm_read_slave_readdata     (readdata),
        .avalonmm_read_slave_waitrequest  (rd_wait),
        .usedw                            (usedw),
        .stall_count                      (stall_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_u(input int n);
        return STAT ? n : 0;
    endfunction

    function automatic logic [31:0] exp_s(input int n);
        return STAT ? n : 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: a read accept happens at the next rising edge with these values.
    initial begin
        forever begin
            @(negedge clock);
            if (read && !rd_wait && !reset) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got 0x%0h expected none", readdata);
                end else begin
                    chk("readdata", readdata, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; decim_factor = 8'd1; write = 1'b0; writedata = '0; read = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_usedw", 32'(usedw), 0);
        chk("rst_rd_wait", 32'(rd_wait), 1);
        chk("rst_wr_wait", 32'(wr_wait), 0);
        chk("rst_stall", 32'(stall_count), 0);
        chk("rst_readdata", readdata, 0);

        // Keep-all fill to the headroom threshold, then drain in order.
        for (int i = 0; i < 13; i++) begin
            chk("fill_wr_wait_low", 32'(wr_wait), 0);
            write = 1'b1; writedata = 32'h11 + i; sb.push_back(32'h11 + i);
            tick();
        end
        write = 1'b0;
        chk("fill_wr_wait_high", 32'(wr_wait), 1);
        chk("fill_usedw", 32'(usedw), exp_u(13));
        read = 1'b1;
        repeat (13) tick();
        read = 1'b0;
        chk("drain_usedw", 32'(usedw), exp_u(0));
        chk("drain_rd_wait", 32'(rd_wait), 1);
        chk("drain_hold_last", readdata, 32'h1D);

        // Decimate by 4: beats 0, 4, 8 kept.
        decim_factor = 8'd4;
        for (int i = 0; i < 12; i++) begin
            write = 1'b1; writedata = i;
            if (i % 4 == 0) sb.push_back(i);
            tick();
        end
        write = 1'b0;
        chk("dec4_usedw", 32'(usedw), exp_u(3));
        read = 1'b1;
        repeat (3) tick();
        read = 1'b0;

        // Factor 8 -> 2 with phase at 5: next beat wraps, following one kept.
        decim_factor = 8'd8;
        for (int i = 0; i < 5; i++) begin
            write = 1'b1; writedata = 32'h30 + i;
            tick();
        end
        sb.push_back(32'h30);
        decim_factor = 8'd2;
        for (int i = 0; i < 7; i++) begin
            write = 1'b1; writedata = 32'h40 + i;
            tick();
        end
        write = 1'b0;
        sb.push_back(32'h41); sb.push_back(32'h43); sb.push_back(32'h45);
        chk("dec_chg_usedw", 32'(usedw), exp_u(4));
        chk("dec_chg_rd_wait", 32'(rd_wait), 0);
        read = 1'b1;
        repeat (4) tick();
        read = 1'b0;

        // Stall statistics and simultaneous read/write.
        decim_factor = 8'd1;
        for (int i = 0; i < 13; i++) begin
            write = 1'b1; writedata = 32'h50 + i; sb.push_back(32'h50 + i);
            tick();
        end
        writedata = 32'hEE;
        repeat (5) tick();
        write = 1'b0;
        chk("stall_count", 32'(stall_count), exp_s(5));
        chk("stall_usedw", 32'(usedw), exp_u(13));
        read = 1'b1;
        tick();
        write = 1'b1; writedata = 32'h5D; sb.push_back(32'h5D);
        tick();
        write = 1'b0; read = 1'b0;
        chk("rw_same_usedw", 32'(usedw), exp_u(12));
        chk("rw_stall_hold", 32'(stall_count), exp_s(5));
        read = 1'b1;
        repeat (12) tick();
        read = 1'b0;
        chk("rw_drain_rd_wait", 32'(rd_wait), 1);

        // No bypass: read with write into an empty FIFO stalls one cycle.
        write = 1'b1; read = 1'b1; writedata = 32'h77; sb.push_back(32'h77);
        chk("nobypass_rd_wait", 32'(rd_wait), 1);
        tick();
        write = 1'b0;
        chk("bypass_next_rd_wait", 32'(rd_wait), 0);
        chk("bypass_next_data", readdata, 32'h77);
        tick();
        read = 1'b0;
        chk("bypass_usedw", 32'(usedw), exp_u(0));
        chk("bypass_rd_wait", 32'(rd_wait), 1);

        // Reset with 7 words and non-zero phase; requests during reset ignored.
        for (int i = 0; i < 6; i++) begin
            write = 1'b1; writedata = 32'h80 + i;
            tick();
        end
        decim_factor = 8'd3;
        writedata = 32'h86;
        tick();
        write = 1'b0;
        chk("pre_rst_usedw", 32'(usedw), exp_u(7));
        reset = 1'b1; write = 1'b1; read = 1'b1; writedata = 32'hDEAD;
        tick();
        reset = 1'b0; write = 1'b0; read = 1'b0;
        chk("mid_rst_usedw", 32'(usedw), 0);
        chk("mid_rst_rd_wait", 32'(rd_wait), 1);
        chk("mid_rst_wr_wait", 32'(wr_wait), 0);
        chk("mid_rst_readdata", readdata, 0);
        chk("mid_rst_stall", 32'(stall_count), 0);
        for (int i = 0; i < 4; i++) begin
            write = 1'b1; writedata = 32'h90 + i;
            if (i % 3 == 0) sb.push_back(32'h90 + i);
            tick();
        end
        write = 1'b0;
        chk("post_rst_usedw", 32'(usedw), exp_u(2));
        read = 1'b1;
        repeat (2) tick();
        read = 1'b0;
        chk("post_rst_rd_wait", 32'(rd_wait), 1);

        tick();
        chk("sb_leftover", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
